// File: rtl/ks_pkg.sv
// -----------------------------------------------------------------------------
// ks_pkg
//   Shared definitions for the Kogge-Stone parallel-prefix carry network.
//
//   Contents:
//     DEFAULT_WIDTH  : default operand width in bits
//     clog2()        : ceiling log2, used to derive the number of prefix levels
//     DEFAULT_LEVELS : prefix levels for DEFAULT_WIDTH
//     gp_t           : {g, p} pair consumed and produced by prefix cells
// -----------------------------------------------------------------------------
package ks_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Ceiling log2 for elaboration-time constants. clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    localparam int DEFAULT_LEVELS = clog2(DEFAULT_WIDTH);

    // Generate/propagate pair for a bit or a group of bits.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage : ks_pkg

// File: rtl/ks_prefix_cell.sv
// -----------------------------------------------------------------------------
// ks_prefix_cell
//   Combinational Kogge-Stone "black cell". Merges a high group with the
//   adjacent lower group into one wider group:
//     Go = Gh | (Ph & Gl)
//     Po = Ph & Pl
//
//   Ports:
//     hi : gp_t  group generate/propagate of the more significant span
//     lo : gp_t  group generate/propagate of the less significant span
//     o  : gp_t  merged generate/propagate of the combined span
// -----------------------------------------------------------------------------
module ks_prefix_cell
    import ks_pkg::*;
(
    input  gp_t hi,
    input  gp_t lo,
    output gp_t o
);

    assign o = '{g: hi.g | (hi.p & lo.g),
                 p: hi.p & lo.p};

endmodule : ks_prefix_cell

// File: rtl/ks_prefix_pipe.sv
// -----------------------------------------------------------------------------
// ks_prefix_pipe
//   Pipelined Kogge-Stone parallel-prefix carry network. Stage 0 registers the
//   bitwise generate/propagate of the operands; stages 1..LEVELS each apply one
//   prefix level (span distance 2^(k-1)) and register the result. The last
//   stage drives the outputs, so a beat appears LEVELS+1 clocks after accept.
//
//   Every stage has its own valid bit and a combinational ready:
//     ready_s = ~valid_s | ready_{s+1},   ready_{LEVELS+1} = out_ready
//   which lets bubbles collapse while the consumer stalls and sustains one
//   beat per clock when out_ready stays high.
//
//   Ports:
//     clk, rst_n          : clock (rising edge), async active-low reset
//     in_valid / in_ready : operand beat handshake
//     a, b, cin           : operands and carry-in
//     out_valid/out_ready : result beat handshake
//     g_grp, p_grp        : group generate/propagate over bits [i:0]
//     p_bit               : bitwise propagate a^b, aligned with the result
//     cin_o               : carry-in, aligned with the result
//   Downstream sum cell i uses carry_i = g_grp[i-1] | p_grp[i-1] & cin_o
//   (carry_0 = cin_o) and sum_i = p_bit[i] ^ carry_i.
// -----------------------------------------------------------------------------
module ks_prefix_pipe
    import ks_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] g_grp,
    output logic [WIDTH-1:0] p_grp,
    output logic [WIDTH-1:0] p_bit,
    output logic             cin_o
);

    localparam int LEVELS = clog2(WIDTH);

    // Stage registers, index 0 = operand stage, index LEVELS = output stage.
    logic [LEVELS:0]            vld_q, vld_d;
    logic [LEVELS:0][WIDTH-1:0] g_q,   g_d;
    logic [LEVELS:0][WIDTH-1:0] p_q,   p_d;
    logic [LEVELS:0][WIDTH-1:0] pb_q,  pb_d;
    logic [LEVELS:0]            cin_q, cin_d;

    // Per-stage ready and combinational prefix results feeding stage k.
    logic [LEVELS:0]            rdy;
    logic [LEVELS:1][WIDTH-1:0] lvl_g;
    logic [LEVELS:1][WIDTH-1:0] lvl_p;

    // -------------------------------------------------------------------------
    // Prefix network: level k merges bit i with bit i-2^(k-1); the low bits
    // already hold their complete [i:0] group and simply pass through.
    // -------------------------------------------------------------------------
    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int DIST = 1 << (k - 1);
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= DIST) begin : g_black
                gp_t cell_hi;
                gp_t cell_lo;
                gp_t cell_o;

                assign cell_hi = '{g: g_q[k-1][i],      p: p_q[k-1][i]};
                assign cell_lo = '{g: g_q[k-1][i-DIST], p: p_q[k-1][i-DIST]};

                ks_prefix_cell u_cell (
                    .hi (cell_hi),
                    .lo (cell_lo),
                    .o  (cell_o)
                );

                assign lvl_g[k][i] = cell_o.g;
                assign lvl_p[k][i] = cell_o.p;
            end else begin : g_pass
                assign lvl_g[k][i] = g_q[k-1][i];
                assign lvl_p[k][i] = p_q[k-1][i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Ready chain, walked from the consumer back to the input. A running
    // variable keeps the chain free of self-dependent vector bits.
    // -------------------------------------------------------------------------
    always_comb begin : ready_chain
        logic nxt_rdy;
        nxt_rdy = out_ready;
        rdy     = '0;
        for (int s = LEVELS; s >= 0; s--) begin
            nxt_rdy = ~vld_q[s] | nxt_rdy;
            rdy[s]  = nxt_rdy;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state for every stage. A stage loads whenever it is ready; its data
    // registers only capture when the upstream beat is valid, so bubbles leave
    // stale data untouched.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a hold value first; a missing
        // default on any path would infer a latch.
        vld_d = vld_q;
        g_d   = g_q;
        p_d   = p_q;
        pb_d  = pb_q;
        cin_d = cin_q;

        if (rdy[0]) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                g_d[0]   = a & b;
                p_d[0]   = a ^ b;
                pb_d[0]  = a ^ b;
                cin_d[0] = cin;
            end
        end

        for (int s = 1; s <= LEVELS; s++) begin
            if (rdy[s]) begin
                vld_d[s] = vld_q[s-1];
                if (vld_q[s-1]) begin
                    g_d[s]   = lvl_g[s];
                    p_d[s]   = lvl_p[s];
                    pb_d[s]  = pb_q[s-1];
                    cin_d[s] = cin_q[s-1];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage registers. Valid bits must clear on reset so in-flight beats are
    // discarded.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            // NOTE: data registers need no reset for correctness (valid gates
            // them), but clearing them keeps outputs deterministic after reset.
            g_q   <= '0;
            p_q   <= '0;
            pb_q  <= '0;
            cin_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the values
            // its neighbours held before this edge.
            vld_q <= vld_d;
            g_q   <= g_d;
            p_q   <= p_d;
            pb_q  <= pb_d;
            cin_q <= cin_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs come straight from the last stage.
    // -------------------------------------------------------------------------
    assign in_ready  = rdy[0];
    assign out_valid = vld_q[LEVELS];
    assign g_grp     = g_q[LEVELS];
    assign p_grp     = p_q[LEVELS];
    assign p_bit     = pb_q[LEVELS];
    assign cin_o     = cin_q[LEVELS];

endmodule : ks_prefix_pipe

// File: doc/ks_prefix_pipe.md
Name: ks_prefix_pipe

Overview:
Pipelined Kogge-Stone parallel-prefix carry network feeding the per-bit sum/carry unit array. It accepts operands A, B and a carry-in, forms bitwise generate/propagate, and runs clog2(WIDTH) prefix levels with one register stage per level. Per bit it emits group generate/propagate over [i:0], the bit propagate, and the carry-in, which is exactly what each downstream sum cell consumes (Cout = G | P&Cin, Sum = Pi ^ carry-into-bit). A valid/ready handshake with full per-stage stall allows streaming at one operation per clock.

Parameters:
WIDTH, 16, operand width in bits (power of two, >= 2)
LEVELS, clog2(WIDTH), number of prefix levels (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result this cycle
g_grp  out  WIDTH  group generate over bits [i:0]
p_grp  out  WIDTH  group propagate over bits [i:0]
p_bit  out  WIDTH  bitwise propagate a^b (registered copy)
cin_o  out  1  carry-in aligned with the result

Behaviour:
- Reset (async assert, sync deassert by clock edge): all stage valid bits = 0; out_valid = 0; g_grp, p_grp, p_bit = 0; cin_o = 0. in_ready = 1 once out of reset.
- Stage 0: on accept (in_valid & in_ready), register g = a&b, p = a^b, cin.
- Stage k (1..LEVELS), distance d = 2^(k-1): for i >= d: G[i] = G[i] | P[i]&G[i-d], P[i] = P[i]&P[i-d]; for i < d: pass through. p_bit and cin travel alongside unchanged.
- Latency: LEVELS+1 cycles from accept to out_valid (WIDTH=16: 5 cycles).
- Handshake per stage s: ready_s = ~valid_s | ready_{s+1}; ready_{last+1} = out_ready; in_ready = ready_0. Stage loads when ready_s; valid_s <= valid_{s-1} when loading. Combinational ready chain is allowed; no skid buffer.
- Throughput: 1 beat/clk when out_ready held high; bubbles collapse while downstream stalls.
- Backpressure: out_valid and all outputs held stable while out_valid & ~out_ready. Pipeline holds up to LEVELS+1 beats; in_ready = 0 only when every stage is full and out_ready = 0.
- Order preserved; no beat dropped or duplicated.
- Simultaneous accept at input and output of a full pipeline: both transfer, occupancy unchanged.
- in_valid with in_ready = 0: a, b, cin are ignored; the source must hold them.
- Reset mid-operation: all in-flight beats discarded; out_valid = 0 asynchronously.
- Data registers need not be reset functionally but are reset to 0 for determinism.

Decomposition:
- Shared package ks_pkg: default WIDTH, clog2 function, LEVELS derivation; also a gp_t pair typedef {g, p} used by the prefix and sum stages.
- One sub-module: ks_prefix_cell (combinational black cell: Go = Gh | Ph&Gl, Po = Ph&Pl), instantiated per bit per level via generate. Pipeline registers and handshake stay in ks_prefix_pipe.

Test Plan:
- Reset, then a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> after 5 clk: out_valid=1, g_grp=0xFFFF, p_grp=0x0000, p_bit=0xFFFE, cin_o=0. The sum array then gives sum=0x0000, cout=1.
- a=0x00FF, b=0x0000, cin=1 -> g_grp=0x0000, p_grp=0x00FF, p_bit=0x00FF, cin_o=1. The sum array then gives sum=0x0100, cout=0.
- Stream 100 random beats back-to-back with out_ready=1 -> in_ready constantly 1; one result/clk after 5-clk fill; every g_grp/p_grp matches the golden prefix model; order preserved.
- out_ready=0 while feeding 8 beats -> accepts exactly 5, then in_ready=0. Outputs stay stable for the first beat. Raising out_ready drains all 5 in order, then the remaining 3 are accepted.
- Random out_ready toggling (50%) with random in_valid over 1000 beats -> no loss or duplication; scoreboard matches.
- Assert rst_n low with 3 beats in flight -> out_valid=0 immediately and all outputs 0. After release, the first new beat appears 5 clk after accept and no stale beat emerges.
